// File: rtl/snooper_pkg.sv
// Shared snooper types: the core-side trace record, control-transfer type codes
// and the CTR recorder's state and buffer-entry types.
package snooper_pkg;

  localparam int CTR_TYPE_W = 4;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef enum logic [CTR_TYPE_W-1:0] {
    CTR_TYPE_NONE    = 4'd0,
    CTR_TYPE_EXC     = 4'd1,
    CTR_TYPE_INTR    = 4'd2,
    CTR_TYPE_TRET    = 4'd3,
    CTR_TYPE_NTBR    = 4'd4,
    CTR_TYPE_TKBR    = 4'd5,
    CTR_TYPE_RSVD6   = 4'd6,
    CTR_TYPE_RSVD7   = 4'd7,
    CTR_TYPE_INDCALL = 4'd8,
    CTR_TYPE_DIRCALL = 4'd9,
    CTR_TYPE_INDJMP  = 4'd10,
    CTR_TYPE_DIRJMP  = 4'd11,
    CTR_TYPE_CORSWAP = 4'd12,
    CTR_TYPE_RET     = 4'd13,
    CTR_TYPE_INDLJMP = 4'd14,
    CTR_TYPE_DIRLJMP = 4'd15
  } ctr_type_t;

  typedef struct packed {
    logic [31:0] src_pc;
    logic [31:0] dst_pc;
    logic [1:0]  priv_lvl;
  } trace_t;

  typedef enum logic [1:0] {
    CTR_DISABLED = 2'd0,
    CTR_RECORD   = 2'd1,
    CTR_FROZEN   = 2'd2
  } ctr_state_e;

  typedef struct packed {
    trace_t    trace;
    ctr_type_t ctype;
  } ctr_entry_t;

endpackage

// File: rtl/snooper_ctr_buf.sv
// Circular record store: push at tail, pop at head; a push into a full buffer
// advances head too, so the oldest entry is overwritten.
module snooper_ctr_buf
  import snooper_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  ctr_entry_t                 wdata_i,
  output ctr_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  ctr_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             adv_head;

  assign full_o   = (count == CNT_W'(DEPTH));
  assign empty_o  = (count == '0);
  assign do_pop   = pop_i & ~empty_o;
  assign adv_head = do_pop | (push_i & full_o);
  assign head_o   = mem[head];
  assign count_o  = count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_i)   tail <= tail + PTR_W'(1);
      if (adv_head) head <= head + PTR_W'(1);
      // push into full (with or without pop) keeps count at DEPTH
      case ({push_i, do_pop})
        2'b10:   if (!full_o) count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && !clear_i && push_i) mem[tail] <= wdata_i;
  end

endmodule

// File: rtl/snooper_ctr_ctrl.sv
// CTR recording controller: type/privilege filter, FSM, drop counter and drain.
// Build option SNOOPER_CTR_FREEZE_ON_FULL_EN: freeze instead of overwriting when full.
module snooper_ctr_ctrl
  import snooper_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       trace_valid_i,
  input  trace_t                     trace_i,
  input  ctr_type_t                  ctr_type_i,
  input  logic                       cfg_enable_i,
  input  logic [15:0]                cfg_type_mask_i,
  input  logic [3:0]                 cfg_priv_mask_i,
  input  logic                       freeze_i,
  input  logic                       unfreeze_i,
  input  logic                       clear_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output trace_t                     out_trace_o,
  output ctr_type_t                  out_type_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [DROP_W-1:0]          drop_cnt_o,
  output logic                       frozen_o,
  output logic [1:0]                 state_o
);

  ctr_state_e  state;
  ctr_state_e  state_next;
  logic        accept;
  logic        pop;
  logic        push;
  logic        overflow;
  logic        freeze_full;
  logic        full;
  logic        empty;
  ctr_entry_t  wdata;
  ctr_entry_t  head;

  assign wdata       = '{trace: trace_i, ctype: ctr_type_i};
  assign pop         = ~empty & out_ready_i;
  assign overflow    = accept & full & ~pop;
  assign out_valid_o = ~empty;
  assign out_trace_o = head.trace;
  assign out_type_o  = head.ctype;

`ifdef SNOOPER_CTR_FREEZE_ON_FULL_EN
  // keep the oldest history: refuse the write and freeze next edge
  assign push        = accept & (~full | pop);
  assign freeze_full = overflow;
`else
  assign push        = accept;
  assign freeze_full = 1'b0;
`endif

  snooper_ctr_buf #(.DEPTH(DEPTH)) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .head_o  (head),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i)                     drop_cnt_o <= '0;
    else if (overflow && (drop_cnt_o != '1))    drop_cnt_o <= drop_cnt_o + DROP_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= CTR_DISABLED;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!cfg_enable_i) begin
      state_next = CTR_DISABLED;
    end else begin
      case (state)
        CTR_DISABLED: state_next = CTR_RECORD;
        CTR_RECORD:   if (!clear_i && (freeze_i || freeze_full)) state_next = CTR_FROZEN;
        CTR_FROZEN:   if (clear_i || (unfreeze_i && !freeze_i)) state_next = CTR_RECORD;
        default:      state_next = CTR_DISABLED;
      endcase
    end
  end

  always_comb begin
    frozen_o = (state == CTR_FROZEN);
    state_o  = state;
    accept   = trace_valid_i && (state == CTR_RECORD) &&
               (ctr_type_i != CTR_TYPE_NONE) &&
               cfg_type_mask_i[ctr_type_i] &&
               cfg_priv_mask_i[trace_i.priv_lvl];
  end

endmodule

// File: tb/tb_snooper_ctr_ctrl.sv
// Self-checking bench for snooper_ctr_ctrl against a queue-based reference model.
module tb_snooper_ctr_ctrl;
  import snooper_pkg::*;

  localparam int DEPTH    = 16;
  localparam int DROP_W   = 4;
  localparam int CNT_W    = $clog2(DEPTH+1);
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              trace_valid_i = 1'b0;
  trace_t            trace_i = '0;
  ctr_type_t         ctr_type_i = CTR_TYPE_NONE;
  logic              cfg_enable_i = 1'b0;
  logic [15:0]       cfg_type_mask_i = '0;
  logic [3:0]        cfg_priv_mask_i = '0;
  logic              freeze_i = 1'b0;
  logic              unfreeze_i = 1'b0;
  logic              clear_i = 1'b0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  trace_t            out_trace_o;
  ctr_type_t         out_type_o;
  logic [CNT_W-1:0]  count_o;
  logic [DROP_W-1:0] drop_cnt_o;
  logic              frozen_o;
  logic [1:0]        state_o;

  int vectors = 0;
  int miscompares = 0;

  // reference model: the buffer is a plain queue, oldest at index 0
  ctr_entry_t mq[$];
  ctr_entry_t sent[$];
  int         m_drop = 0;
  int         m_state = 0;

  snooper_ctr_ctrl #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .trace_valid_i   (trace_valid_i),
    .trace_i         (trace_i),
    .ctr_type_i      (ctr_type_i),
    .cfg_enable_i    (cfg_enable_i),
    .cfg_type_mask_i (cfg_type_mask_i),
    .cfg_priv_mask_i (cfg_priv_mask_i),
    .freeze_i        (freeze_i),
    .unfreeze_i      (unfreeze_i),
    .clear_i         (clear_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_trace_o     (out_trace_o),
    .out_type_o      (out_type_o),
    .count_o         (count_o),
    .drop_cnt_o      (drop_cnt_o),
    .frozen_o        (frozen_o),
    .state_o         (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_step();
    bit pop, acc, full_no_pop;
    int ns;
    ctr_entry_t e;
    if (!rst_ni) begin
      mq.delete();
      m_drop  = 0;
      m_state = 0;
      return;
    end
    e   = '{trace: trace_i, ctype: ctr_type_i};
    pop = (mq.size() > 0) && out_ready_i;
    acc = trace_valid_i && (m_state == 1) && (ctr_type_i != CTR_TYPE_NONE) &&
          cfg_type_mask_i[int'(ctr_type_i)] && cfg_priv_mask_i[int'(trace_i.priv_lvl)];
    full_no_pop = acc && (mq.size() == DEPTH) && !pop;
    ns = m_state;
    if (!cfg_enable_i) ns = 0;
    else if (m_state == 0) ns = 1;
    else if (m_state == 1) begin
      if (!clear_i && freeze_i) ns = 2;
`ifdef SNOOPER_CTR_FREEZE_ON_FULL_EN
      if (!clear_i && full_no_pop) ns = 2;
`endif
    end else if (clear_i || (unfreeze_i && !freeze_i)) ns = 1;
    if (clear_i) begin
      mq.delete();
      m_drop = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (full_no_pop) begin
        m_drop = (m_drop + 1 > DROP_MAX) ? DROP_MAX : m_drop + 1;
`ifndef SNOOPER_CTR_FREEZE_ON_FULL_EN
        void'(mq.pop_front());
        mq.push_back(e);
`endif
      end else if (acc) begin
        mq.push_back(e);
      end
    end
    m_state = ns;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_rec(input ctr_type_t t, input logic [1:0] p, input logic rdy);
    trace_i       = '{src_pc: $urandom, dst_pc: $urandom, priv_lvl: p};
    ctr_type_i    = t;
    trace_valid_i = 1'b1;
    out_ready_i   = rdy;
    sent.push_back('{trace: trace_i, ctype: t});
    cyc();
    trace_valid_i = 1'b0;
    out_ready_i   = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; cfg_enable_i = 1'b1; trace_valid_i = 1'b1; out_ready_i = 1'b1;
    ctr_type_i = CTR_TYPE_TKBR; cfg_type_mask_i = '1; cfg_priv_mask_i = '1;
    cyc(); cyc();
    vectors += 5;
    if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid_o); end
    if (count_o !== '0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count_o); end
    if (drop_cnt_o !== '0) begin miscompares++; $display("FAIL reset_drop got %0d want 0", drop_cnt_o); end
    if (frozen_o !== 1'b0) begin miscompares++; $display("FAIL reset_frozen got %b want 0", frozen_o); end
    if (state_o !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", state_o); end
    rst_ni = 1'b1; cfg_enable_i = 1'b0; trace_valid_i = 1'b0; out_ready_i = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    cfg_enable_i = 1'b1; cfg_type_mask_i = '1; cfg_priv_mask_i = '1;
    cyc();
    vectors += 2;
    if (state_o !== 2'd1) begin miscompares++; $display("FAIL basic_state got %0d want 1", state_o); end
    if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL basic_prevalid got %b want 0", out_valid_o); end
    sent.delete();
    push_rec(CTR_TYPE_TKBR, PRIV_M, 1'b0);
    vectors += 2;
    if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL basic_latency got %b want 1", out_valid_o); end
    if (out_trace_o !== sent[0].trace) begin miscompares++; $display("FAIL basic_first got %h want %h", out_trace_o, sent[0].trace); end
    push_rec(CTR_TYPE_TKBR, PRIV_S, 1'b0);
    push_rec(CTR_TYPE_TKBR, PRIV_U, 1'b0);
    vectors += 3;
    if (count_o !== CNT_W'(3)) begin miscompares++; $display("FAIL basic_count got %0d want 3", count_o); end
    if (out_trace_o !== sent[0].trace) begin miscompares++; $display("FAIL basic_stable got %h want %h", out_trace_o, sent[0].trace); end
    if (out_type_o !== CTR_TYPE_TKBR) begin miscompares++; $display("FAIL basic_type got %0d want %0d", out_type_o, CTR_TYPE_TKBR); end
  endtask

  task automatic test_filter();
    pulse_clear();
    vectors++;
    if (count_o !== '0) begin miscompares++; $display("FAIL filter_clear got %0d want 0", count_o); end
    cfg_type_mask_i = 16'h0020; cfg_priv_mask_i = 4'b1000;
    sent.delete();
    push_rec(CTR_TYPE_TKBR, PRIV_U, 1'b0);
    push_rec(CTR_TYPE_NTBR, PRIV_M, 1'b0);
    push_rec(CTR_TYPE_TKBR, PRIV_M, 1'b0);
    push_rec(CTR_TYPE_NONE, PRIV_M, 1'b0);
    vectors += 3;
    if (count_o !== CNT_W'(1)) begin miscompares++; $display("FAIL filter_count got %0d want 1", count_o); end
    if (out_trace_o !== sent[2].trace) begin miscompares++; $display("FAIL filter_rec got %h want %h", out_trace_o, sent[2].trace); end
    if (drop_cnt_o !== '0) begin miscompares++; $display("FAIL filter_drop got %0d want 0", drop_cnt_o); end
    cfg_type_mask_i = '1; cfg_priv_mask_i = '1;
  endtask

  task automatic test_overflow();
    pulse_clear();
    sent.delete();
    for (int i = 0; i < 18; i++) push_rec(CTR_TYPE_TKBR, PRIV_M, 1'b0);
    vectors += 4;
    if (count_o !== CNT_W'(16)) begin miscompares++; $display("FAIL ovf_count got %0d want 16", count_o); end
`ifdef SNOOPER_CTR_FREEZE_ON_FULL_EN
    if (drop_cnt_o !== DROP_W'(1)) begin miscompares++; $display("FAIL ovf_drop got %0d want 1", drop_cnt_o); end
    if (out_trace_o !== sent[0].trace) begin miscompares++; $display("FAIL ovf_head got %h want %h", out_trace_o, sent[0].trace); end
    if (frozen_o !== 1'b1) begin miscompares++; $display("FAIL ovf_frozen got %b want 1", frozen_o); end
`else
    if (drop_cnt_o !== DROP_W'(2)) begin miscompares++; $display("FAIL ovf_drop got %0d want 2", drop_cnt_o); end
    if (out_trace_o !== sent[2].trace) begin miscompares++; $display("FAIL ovf_head got %h want %h", out_trace_o, sent[2].trace); end
    if (frozen_o !== 1'b0) begin miscompares++; $display("FAIL ovf_frozen got %b want 0", frozen_o); end
`endif
  endtask

  task automatic test_full_push_pop();
    int d0;
    unfreeze_i = 1'b1;
    cyc();
    unfreeze_i = 1'b0;
    d0 = m_drop;
    push_rec(CTR_TYPE_RET, PRIV_S, 1'b1);
    vectors += 2;
    if (count_o !== CNT_W'(16)) begin miscompares++; $display("FAIL fpp_count got %0d want 16", count_o); end
    if (drop_cnt_o !== DROP_W'(d0)) begin miscompares++; $display("FAIL fpp_drop got %0d want %0d", drop_cnt_o, d0); end
    for (int i = 0; i < 16; i++) begin
      vectors += 2;
      if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL drain_valid[%0d] got %b want 1", i, out_valid_o); end
      if (mq.size() > 0 && out_trace_o !== mq[0].trace) begin miscompares++; $display("FAIL drain_data[%0d] got %h want %h", i, out_trace_o, mq[0].trace); end
      if (i == 15) begin
        vectors++;
        if (out_trace_o !== sent[sent.size()-1].trace || out_type_o !== CTR_TYPE_RET) begin
          miscompares++; $display("FAIL fpp_last got %h want %h", out_trace_o, sent[sent.size()-1].trace);
        end
      end
      out_ready_i = 1'b1;
      cyc();
      out_ready_i = 1'b0;
    end
    vectors++;
    if (out_valid_o !== 1'b0 || count_o !== '0) begin miscompares++; $display("FAIL drain_empty got valid=%b count=%0d want 0/0", out_valid_o, count_o); end
  endtask

  task automatic test_freeze();
    pulse_clear();
    push_rec(CTR_TYPE_TKBR, PRIV_M, 1'b0);
    push_rec(CTR_TYPE_DIRCALL, PRIV_U, 1'b0);
    freeze_i = 1'b1; cyc(); freeze_i = 1'b0;
    vectors++;
    if (frozen_o !== 1'b1) begin miscompares++; $display("FAIL frz_frozen got %b want 1", frozen_o); end
    for (int i = 0; i < 4; i++) push_rec(CTR_TYPE_TKBR, PRIV_M, 1'b0);
    vectors++;
    if (count_o !== CNT_W'(2)) begin miscompares++; $display("FAIL frz_count got %0d want 2", count_o); end
    unfreeze_i = 1'b1; cyc(); unfreeze_i = 1'b0;
    push_rec(CTR_TYPE_TKBR, PRIV_M, 1'b0);
    vectors += 2;
    if (frozen_o !== 1'b0) begin miscompares++; $display("FAIL unfrz_frozen got %b want 0", frozen_o); end
    if (count_o !== CNT_W'(3)) begin miscompares++; $display("FAIL unfrz_count got %0d want 3", count_o); end
    freeze_i = 1'b1; unfreeze_i = 1'b1; cyc();
    vectors++;
    if (frozen_o !== 1'b1) begin miscompares++; $display("FAIL frz_both_rec got %b want 1", frozen_o); end
    cyc();
    freeze_i = 1'b0; unfreeze_i = 1'b0;
    vectors++;
    if (frozen_o !== 1'b1) begin miscompares++; $display("FAIL frz_both_frz got %b want 1", frozen_o); end
    unfreeze_i = 1'b1; cyc(); unfreeze_i = 1'b0;
  endtask

  task automatic test_saturate();
    pulse_clear();
    for (int i = 0; i < 36; i++) push_rec(CTR_TYPE_INDJMP, PRIV_M, 1'b0);
    vectors += 2;
    if (drop_cnt_o !== DROP_W'(m_drop)) begin miscompares++; $display("FAIL sat_model got %0d want %0d", drop_cnt_o, m_drop); end
`ifdef SNOOPER_CTR_FREEZE_ON_FULL_EN
    if (drop_cnt_o !== DROP_W'(1)) begin miscompares++; $display("FAIL sat_drop got %0d want 1", drop_cnt_o); end
`else
    if (drop_cnt_o !== DROP_W'(DROP_MAX)) begin miscompares++; $display("FAIL sat_drop got %0d want %0d", drop_cnt_o, DROP_MAX); end
`endif
    unfreeze_i = 1'b1; cyc(); unfreeze_i = 1'b0;
  endtask

  task automatic test_clear_mid();
    clear_i = 1'b1;
    push_rec(CTR_TYPE_TKBR, PRIV_M, 1'b1);
    clear_i = 1'b0;
    vectors += 3;
    if (count_o !== '0) begin miscompares++; $display("FAIL clr_count got %0d want 0", count_o); end
    if (drop_cnt_o !== '0) begin miscompares++; $display("FAIL clr_drop got %0d want 0", drop_cnt_o); end
    if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL clr_valid got %b want 0", out_valid_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cfg_enable_i  = ($urandom_range(0, 29) != 0);
      trace_valid_i = ($urandom_range(0, 3) != 0);
      trace_i       = '{src_pc: $urandom, dst_pc: $urandom, priv_lvl: 2'($urandom_range(0, 3))};
      ctr_type_i    = ctr_type_t'(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 49) == 0) begin
        cfg_type_mask_i = 16'($urandom) | 16'h00f0;
        cfg_priv_mask_i = 4'($urandom) | 4'b1000;
      end
      freeze_i    = ($urandom_range(0, 39) == 0);
      unfreeze_i  = ($urandom_range(0, 7) == 0);
      clear_i     = ($urandom_range(0, 99) == 0);
      out_ready_i = (i < 300) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      cyc();
      vectors += 4;
      if (count_o !== CNT_W'(mq.size())) begin miscompares++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count_o, mq.size()); end
      if (out_valid_o !== (mq.size() > 0)) begin miscompares++; $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid_o, mq.size() > 0); end
      if (drop_cnt_o !== DROP_W'(m_drop)) begin miscompares++; $display("FAIL rnd_drop[%0d] got %0d want %0d", i, drop_cnt_o, m_drop); end
      if (state_o !== 2'(m_state)) begin miscompares++; $display("FAIL rnd_state[%0d] got %0d want %0d", i, state_o, m_state); end
      if (mq.size() > 0) begin
        vectors++;
        if (out_trace_o !== mq[0].trace || out_type_o !== mq[0].ctype) begin
          miscompares++; $display("FAIL rnd_head[%0d] got %h/%0d want %h/%0d", i, out_trace_o, out_type_o, mq[0].trace, mq[0].ctype);
        end
      end
    end
    trace_valid_i = 1'b0; freeze_i = 1'b0; unfreeze_i = 1'b0; clear_i = 1'b0; out_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    cfg_enable_i = 1'b1; cfg_type_mask_i = '1; cfg_priv_mask_i = '1;
    cyc();
    pulse_clear();
    unfreeze_i = 1'b1; cyc(); unfreeze_i = 1'b0;
    for (int i = 0; i < 5; i++) push_rec(CTR_TYPE_TKBR, PRIV_M, 1'b0);
    vectors++;
    if (count_o !== CNT_W'(5)) begin miscompares++; $display("FAIL rstmid_pre got %0d want 5", count_o); end
    rst_ni = 1'b0; out_ready_i = 1'b1; trace_valid_i = 1'b1;
    cyc();
    vectors += 5;
    if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid got %b want 0", out_valid_o); end
    if (count_o !== '0) begin miscompares++; $display("FAIL rstmid_count got %0d want 0", count_o); end
    if (drop_cnt_o !== '0) begin miscompares++; $display("FAIL rstmid_drop got %0d want 0", drop_cnt_o); end
    if (frozen_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_frozen got %b want 0", frozen_o); end
    if (state_o !== 2'd0) begin miscompares++; $display("FAIL rstmid_state got %0d want 0", state_o); end
    rst_ni = 1'b1; out_ready_i = 1'b0; trace_valid_i = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_freeze();
    test_saturate();
    test_clear_mid();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snooper_ctr_ctrl.md
Name: snooper_ctr_ctrl

Overview:
- Recording controller for the control-transfer-record (CTR) snooper path.
- Takes the per-cycle trace record (trace_t plus ctr_type_t) from the core-side snooper and filters it by transfer type and privilege level.
- Stores accepted records in an internal circular buffer with overwrite-oldest semantics and freeze control.
- Drains the oldest record over a valid/ready stream toward the trace sink or register readout.

Parameters:
- DEPTH, 16, number of buffered records; power of two, at least 2.
- DROP_W, 16, width of the saturating dropped/overwritten-record counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- trace_valid_i  in  1  trace_i/ctr_type_i valid this cycle; no backpressure.
- trace_i  in  $bits(trace_t)  snooper_pkg::trace_t record.
- ctr_type_i  in  4  snooper_pkg::ctr_type_t of the record.
- cfg_enable_i  in  1  recording enable, level.
- cfg_type_mask_i  in  16  bit n set: accept ctr_type value n.
- cfg_priv_mask_i  in  4  bit p set: accept priv_lvl encoding p (U=0, S=1, M=3).
- freeze_i  in  1  single-cycle pulse; stop recording.
- unfreeze_i  in  1  single-cycle pulse; resume recording.
- clear_i  in  1  single-cycle pulse; flush buffer and drop counter.
- out_valid_o  out  1  oldest record available.
- out_ready_i  in  1  sink accepts the record.
- out_trace_o  out  $bits(trace_t)  oldest record.
- out_type_o  out  4  ctr_type of the oldest record.
- count_o  out  $clog2(DEPTH+1)  occupancy.
- drop_cnt_o  out  DROP_W  saturating count of overwritten/dropped records.
- frozen_o  out  1  state == FROZEN.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - State DISABLED; head, tail and count cleared.
  - All outputs 0: out_valid_o, count_o, drop_cnt_o, frozen_o, state_o=0.
  - Buffer contents are don't-care.
  - Reset mid-operation discards all records; no partial pop.
- FSM, encoded DISABLED=0, RECORD=1, FROZEN=2:
  - DISABLED -> RECORD when cfg_enable_i=1.
  - RECORD -> FROZEN on freeze_i.
  - FROZEN -> RECORD on unfreeze_i or clear_i, if enabled.
  - Any state -> DISABLED when cfg_enable_i=0. Buffer is retained and drain continues.
  - freeze_i and unfreeze_i in the same cycle: freeze wins.
- Accept condition, evaluated combinationally in the same cycle:
  - trace_valid_i=1 and state==RECORD, and
  - ctr_type_i != CTR_TYPE_NONE, and
  - cfg_type_mask_i[ctr_type_i]=1 and cfg_priv_mask_i[trace_i.priv_lvl]=1.
  - Non-accepted records are silently ignored and do not count as drops.
- Push: an accepted record is written at tail on the same edge.
  - out_valid_o rises the next cycle, so push-to-output latency is 1 cycle.
  - No combinational bypass.
- Pop: out_valid_o & out_ready_i advances head.
  - out_trace_o/out_type_o are stable while out_valid_o=1 and out_ready_i=0.
- Full, accept, no pop: overwrite the oldest entry (write at tail, advance head and tail), count stays DEPTH, drop_cnt_o++.
- Full, accept and pop in the same cycle: pop the oldest, push the new record, count stays DEPTH, no drop.
- Empty, accept and out_ready_i=1: push only. out_valid_o was 0, so nothing pops.
- drop_cnt_o saturates at all-ones with no wrap.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- clear_i has highest priority after reset:
  - Empties the buffer and zeros drop_cnt_o; a same-cycle push and pop are discarded.
  - Leaves FROZEN as defined above; other states are unchanged.

Optional Feature:
- Macro: SNOOPER_CTR_FREEZE_ON_FULL_EN.
- Defined:
  - An accepted record arriving when the buffer is full with no same-cycle pop is not written.
  - drop_cnt_o increments and the FSM enters FROZEN on the next edge, preserving the oldest history.
  - Full with a same-cycle pop behaves as normal push+pop.
- Undefined: overwrite-oldest behaviour as specified above.

Decomposition:
- Add to snooper_pkg:
  - ctr_state_e (DISABLED/RECORD/FROZEN, logic[1:0]).
  - ctr_entry_t packed struct {trace_t trace; ctr_type_t ctype;}.
  - Localparam CTR_TYPE_W=4.
- Sub-module snooper_ctr_buf: DEPTH-entry ctr_entry_t circular storage with push, pop and overwrite, exposing head entry, count and full/empty flags. The FSM, filter and drop counter stay in snooper_ctr_ctrl.

Test Plan:
- Reset then enable, mask all types and privs, 3 pushes of CTR_TYPE_TKBR with out_ready_i=0 -> count_o=3, out_valid_o=1 one cycle after the first push, out_trace_o equals the first record.
- Filter: cfg_type_mask_i=16'h0020 (TKBR only), cfg_priv_mask_i=4'b1000 (M only); send TKBR/U, NTBR/M, TKBR/M, NONE/M -> exactly one record (TKBR/M) stored.
- Overflow with DEPTH=16: 18 pushes and no pops -> count_o=16, drop_cnt_o=2, out_trace_o equals the 3rd record. Under SNOOPER_CTR_FREEZE_ON_FULL_EN: head is the 1st record, frozen_o=1, drop_cnt_o=1, and the 18th record is ignored with no drop.
- Full with simultaneous push and pop -> count_o stays 16, drop_cnt_o unchanged, the new record is last out.
- Freeze/unfreeze: freeze_i, then 4 valid records -> count_o unchanged; unfreeze_i, 1 record -> count_o+1. freeze_i and unfreeze_i in the same cycle -> frozen_o=1.
- Mid-operation: clear_i with a push and a pop in the same cycle -> count_o=0, drop_cnt_o=0, out_valid_o=0 next cycle. rst_ni=0 mid-drain -> all outputs 0 the next cycle.
